// File: rtl/unidad_control_multiciclo.sv
// unidad_control_multiciclo: multicycle main control FSM for the RV32I core.
// Sequences the shared datapath through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// and stalls on the MemReady handshake.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal opcode traps into an
// absorbing TRAP state; otherwise it retires as a NOP and Illegal stays 0).
module unidad_control_multiciclo (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmScr,
  output logic       InstrDone,
  output logic       Illegal
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    EXECI,
    ALUWB,
    BEQ,
    JAL,
    LUI
`ifdef ILLEGAL_TRAP_EN
    ,
    TRAP
`endif
  } state_t;

  state_t state, state_n, state_eff;
  logic   op_legal;

  // Opcode legality, shared by next-state and DECODE outputs
  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_LUI: op_legal = 1'b1;
      default:                                         op_legal = 1'b0;
    endcase
  end

  // Immediate format select, purely from the opcode
  always_comb begin
    ImmScr = 3'b000;
    case (op)
      OP_LW, OP_I: ImmScr = 3'b000;
      OP_SW:       ImmScr = 3'b001;
      OP_BR:       ImmScr = 3'b101;
      OP_LUI:      ImmScr = 3'b010;
      OP_JAL:      ImmScr = 3'b110;
      default:     ImmScr = 3'b000;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      FETCH:    if (MemReady) state_n = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_n = MEMADR;
          OP_R:         state_n = EXECR;
          OP_I:         state_n = EXECI;
          OP_BR:        state_n = BEQ;
          OP_JAL:       state_n = JAL;
          OP_LUI:       state_n = LUI;
`ifdef ILLEGAL_TRAP_EN
          default:      state_n = TRAP;
`else
          default:      state_n = FETCH;
`endif
        endcase
      end
      MEMADR:   state_n = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (MemReady) state_n = MEMWB;
      MEMWB:    state_n = FETCH;
      MEMWRITE: if (MemReady) state_n = FETCH;
      EXECR:    state_n = ALUWB;
      EXECI:    state_n = ALUWB;
      ALUWB:    state_n = FETCH;
      BEQ:      state_n = FETCH;
      JAL:      state_n = ALUWB;
      LUI:      state_n = ALUWB;
`ifdef ILLEGAL_TRAP_EN
      TRAP:     state_n = TRAP;
`endif
      default:  state_n = FETCH;
    endcase
  end

  // Output decode; while reset is high the FETCH selects are shown with all
  // write enables and InstrDone suppressed, so an aborted instruction writes nothing
  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    InstrDone = 1'b0;
    Illegal   = 1'b0;
    state_eff = reset ? FETCH : state;
    case (state_eff)
      FETCH: begin
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b10;
        ALUOp     = 2'b00;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b01;
        ALUOp     = 2'b00;
`ifndef ILLEGAL_TRAP_EN
        InstrDone = ~op_legal;
`endif
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b00;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        MemWrite  = 1'b1;
        InstrDone = MemReady;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b00;
        ALUOp   = 2'b10;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      ALUWB: begin
        ResultSrc = 2'b00;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      BEQ: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b01;
        ResultSrc = 2'b00;
        InstrDone = 1'b1;
        case (funct3)
          3'b000:  PCWrite = Zero;
          3'b001:  PCWrite = ~Zero;
          default: PCWrite = 1'b0;
        endcase
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ALUOp     = 2'b00;
        ResultSrc = 2'b00;
        PCWrite   = 1'b1;
      end
      LUI: begin
        ALUSrcA = 2'b00;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: Illegal = 1'b1;
`endif
      default: ;
    endcase
    if (reset) begin
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      MemWrite  = 1'b0;
      InstrDone = 1'b0;
    end
  end

endmodule

// File: doc/unidad_control_multiciclo.md
# unidad_control_multiciclo

Multicycle main control FSM for the RV32I core. It sequences the shared datapath (one memory port, one ALU, instruction register, register file and immediate generator) across FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK states. It produces every mux select, write enable and ImmScr code, and stalls on a memory ready handshake. It sits beside the datapath and decodes the opcode held in the instruction register.

## Interface
Parameters:
- none; encodings are fixed below.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- op  in  7  opcode bits [6:0] of the instruction register.
- funct3  in  3  instruction bits [14:12].
- Zero  in  1  ALU zero flag, valid in the BEQ state.
- MemReady  in  1  memory handshake; access completes on a cycle with MemReady=1.
- PCWrite  out  1  PC load enable.
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
- MemWrite  out  1  data memory write strobe.
- IRWrite  out  1  instruction register and OldPC load.
- RegWrite  out  1  register file write.
- ResultSrc  out  2  result mux: 00=ALUOut, 01=MemData, 10=ALUResult.
- ALUSrcA  out  2  ALU A mux: 00=PC, 01=OldPC, 10=rs1.
- ALUSrcB  out  2  ALU B mux: 00=rs2, 01=ImmExt, 10=constant 4.
- ALUOp  out  2  ALU decoder hint: 00=add, 01=sub, 10=funct-decoded.
- ImmScr  out  3  immediate format: I=000, S=001, B=101, U=010, J=110.
- InstrDone  out  1  one-cycle pulse in the final state of each instruction.
- Illegal  out  1  illegal-opcode flag; see Configuration.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, LUI, TRAP.
- ImmScr is combinational from op, independent of state:
  - lw and I-ALU give 000.
  - sw gives 001.
  - branch gives 101.
  - lui gives 010.
  - jal gives 110.
  - anything else gives 000.
- All outputs not listed for a state are 0.
- FETCH:
  - Drives AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCWrite=MemReady.
  - Moves to DECODE when MemReady=1; otherwise stays.
- DECODE drives ALUSrcA=01, ALUSrcB=01, ALUOp=00 to precompute the branch or jump target. Next state by op:
  - 0000011 or 0100011 goes to MEMADR.
  - 0110011 goes to EXECR.
  - 0010011 goes to EXECI.
  - 1100011 goes to BEQ.
  - 1101111 goes to JAL.
  - 0110111 goes to LUI.
  - Any other op is illegal; see Configuration.
- MEMADR drives ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD for a load, MEMWRITE for a store.
- MEMREAD drives AdrSrc=1 and waits for MemReady=1, then goes to MEMWB.
- MEMWB drives ResultSrc=01, RegWrite=1, InstrDone=1, then goes to FETCH.
- MEMWRITE drives AdrSrc=1, MemWrite=1 and holds until MemReady=1. InstrDone=MemReady. Then goes to FETCH.
- EXECR drives ALUSrcA=10, ALUSrcB=00, ALUOp=10, then goes to ALUWB.
- EXECI drives ALUSrcA=10, ALUSrcB=01, ALUOp=10, then goes to ALUWB.
- ALUWB drives ResultSrc=00, RegWrite=1, InstrDone=1, then goes to FETCH.
- BEQ drives ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, InstrDone=1.
  - PCWrite=Zero when funct3=000.
  - PCWrite=~Zero when funct3=001.
  - PCWrite=0 for any other funct3.
  - Then goes to FETCH.
- JAL drives ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, then goes to ALUWB to write rd=PC+4.
- LUI drives ALUSrcA=00, ALUSrcB=01, ALUOp=10, then goes to ALUWB.
  - The ALU decoder passes B through for op 0110111.

## Timing
- The state register updates on the rising clk edge. Outputs are Moore from state, except:
  - the MemReady gating in FETCH and MEMWRITE;
  - Zero/funct3 in BEQ;
  - ImmScr.
- Behaviour while reset=1:
  - PCWrite, IRWrite, RegWrite, MemWrite and InstrDone are forced to 0.
  - The other outputs show FETCH values.
  - The next state is FETCH.
- Reset mid-instruction aborts it with no write.
- Latency with MemReady held at 1:
  - R, I-ALU, lui, jal and sw: 4 cycles.
  - lw: 5 cycles.
  - Branch: 3 cycles.
- Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Outputs are held constant during the wait.
- InstrDone rises exactly once per instruction.

## Configuration
- Macro ILLEGAL_TRAP_EN, with illegal op in DECODE:
  - Defined:
    - DECODE goes to TRAP.
    - TRAP is absorbing and drives all enables 0 and Illegal=1 until reset.
  - Undefined:
    - The illegal op is a NOP: DECODE goes to FETCH with InstrDone=1.
    - TRAP is not built.
    - Illegal is tied to 0.

## Test plan
- Reset held 2 cycles, then op=0110011, MemReady=1:
  - PCWrite=0 during reset.
  - Then states run FETCH, DECODE, EXECR, ALUWB.
  - RegWrite=1 only in cycle 4; InstrDone=1 only in cycle 4.
- lw (op 0000011) with MemReady=0 for 3 cycles in MEMREAD:
  - Total latency is 8 cycles.
  - AdrSrc=1 is stable throughout the wait.
  - RegWrite=1 with ResultSrc=01 once.
- sw (op 0100011):
  - ImmScr=001.
  - MemWrite=1 exactly until the MemReady=1 cycle.
  - RegWrite is never 1.
- Branch op 1100011:
  - funct3=000 with Zero=1 gives PCWrite=1 in BEQ.
  - funct3=001 with Zero=1 gives PCWrite=0.
  - funct3=100 gives PCWrite=0.
  - ImmScr=101.
- jal (op 1101111):
  - ImmScr=110.
  - PCWrite=1 in JAL, then RegWrite=1 in ALUWB.
  - 4 cycles total.
- op=1111111:
  - With ILLEGAL_TRAP_EN, Illegal=1 persists 10 cycles with no enables, and clears after reset.
  - Without the macro, FETCH is re-entered on the 3rd cycle and Illegal stays 0.
